// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues PCs to an in-order instruction memory and returns {pc, instr} to decode in program order.
// A flush discards queued entries and counts in-flight reads so their late responses are dropped.
module ifetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_req_pc,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic             i_flush,
   output logic             o_mem_req,
   output logic [WIDTH-1:0] o_mem_addr,
   input  logic             i_mem_rvalid,
   input  logic [WIDTH-1:0] i_mem_rdata,
   output logic             o_instr_valid,
   input  logic             i_instr_ready,
   output logic [WIDTH-1:0] o_instr_out,
   output logic [WIDTH-1:0] o_instr_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    r_alloc, r_fill, r_rd, r_drop;
   logic [DEPTH-1:0] r_filled;
   logic [WIDTH-1:0] r_pc   [DEPTH];
   logic [WIDTH-1:0] r_data [DEPTH];

   logic [AW-1:0] w_alloc_idx, w_fill_idx, w_rd_idx;
   logic [PW-1:0] w_occ, w_infl, w_drop_flush;
   logic [PW:0]   w_drop_sum, w_drop_sub;
   logic          w_accept, w_keep, w_pop;

   assign w_alloc_idx = r_alloc[AW-1:0];
   assign w_fill_idx  = r_fill[AW-1:0];
   assign w_rd_idx    = r_rd[AW-1:0];
   assign w_occ       = r_alloc - r_rd;
   assign w_infl      = r_alloc - r_fill;

   assign o_req_ready   = !rst && !i_flush && (w_occ < PW'(DEPTH));
   assign o_mem_req     = i_req_valid && o_req_ready;
   assign o_mem_addr    = i_req_pc;
   assign o_instr_valid = !rst && !i_flush && r_filled[w_rd_idx] && (w_occ != '0);
   assign o_instr_out   = r_data[w_rd_idx];
   assign o_instr_pc    = r_pc[w_rd_idx];

   assign w_accept = o_mem_req;
   assign w_keep   = i_mem_rvalid && (r_drop == '0) && (w_infl != '0);
   assign w_pop    = o_instr_valid && i_instr_ready;

   // A response arriving in the flush cycle is already consumed, so it is not counted as pending.
   assign w_drop_sum   = {1'b0, r_drop} + {1'b0, w_infl};
   assign w_drop_sub   = w_drop_sum - (PW+1)'(i_mem_rvalid && (w_drop_sum != '0));
   assign w_drop_flush = (w_drop_sub > (PW+1)'(DEPTH)) ? PW'(DEPTH) : w_drop_sub[PW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alloc  <= '0;
         r_fill   <= '0;
         r_rd     <= '0;
         r_drop   <= '0;
         r_filled <= '0;
      end else if (i_flush) begin
         r_alloc  <= '0;
         r_fill   <= '0;
         r_rd     <= '0;
         r_drop   <= w_drop_flush;
         r_filled <= '0;
      end else begin
         if (i_mem_rvalid && (r_drop != '0))
            r_drop <= r_drop - PW'(1);
         if (w_accept) begin
            r_filled[w_alloc_idx] <= 1'b0;
            r_alloc               <= r_alloc + PW'(1);
         end
         if (w_keep) begin
            r_filled[w_fill_idx] <= 1'b1;
            r_fill               <= r_fill + PW'(1);
         end
         if (w_pop) begin
            r_filled[w_rd_idx] <= 1'b0;
            r_rd               <= r_rd + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept)
         r_pc[w_alloc_idx] <= i_req_pc;
      if (w_keep && !i_flush && !rst)
         r_data[w_fill_idx] <= i_mem_rdata;
   end
endmodule
